// File: rtl/tdc_multichan_fine_encoder.sv
// Multi-channel carry-chain TDC front end: samples tap vectors, converts them to
// ones-count fine codes with coarse stamps, and merges events round-robin onto one stream.
`timescale 1ns/1ps
module tdc_multichan_fine_encoder #(
    parameter int NCHAN    = 2,
    parameter int NTAPS    = 340,
    parameter int FINE_W   = 9,
    parameter int COARSE_W = 16,
    parameter int CH_W     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NCHAN*NTAPS-1:0] taps,
    input  logic                   ovf_clr,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [CH_W-1:0]        out_chan,
    output logic [FINE_W-1:0]      out_fine,
    output logic [COARSE_W-1:0]    out_coarse,
    output logic                   out_sat,
    output logic [NCHAN-1:0]       ovf
);
    localparam int NGRP = (NTAPS + 3) / 4;
    localparam int NPAD = NGRP * 4;

    logic [COARSE_W-1:0] coarse_reg;
    logic [COARSE_W-1:0] c1_reg, c2_reg, ca_reg, cb_reg;
    logic                vld1_reg, vld2_reg;

    // Candidate event per channel: the pending entry if any, else the fresh one.
    logic [NCHAN-1:0]    cand_vld;
    logic [FINE_W-1:0]   cand_fine   [NCHAN];
    logic [COARSE_W-1:0] cand_coarse [NCHAN];
    logic [NCHAN-1:0]    cand_sat;

    logic                load;
    logic                gnt_vld;
    logic [CH_W-1:0]     gnt_idx;
    logic [CH_W-1:0]     idx;
    logic [CH_W-1:0]     ptr_reg, ptr_next;

    logic                out_valid_reg, out_sat_reg;
    logic [CH_W-1:0]     out_chan_reg;
    logic [FINE_W-1:0]   out_fine_reg;
    logic [COARSE_W-1:0] out_coarse_reg;

    // The coarse stamp is shared by all channels because they capture in lockstep.
    always_ff @(posedge clk) begin
        if (rst) begin
            coarse_reg <= '0;
            c1_reg     <= '0;
            c2_reg     <= '0;
            ca_reg     <= '0;
            cb_reg     <= '0;
            vld1_reg   <= 1'b0;
            vld2_reg   <= 1'b0;
        end else begin
            coarse_reg <= coarse_reg + 1'b1;
            c1_reg     <= coarse_reg;
            c2_reg     <= c1_reg;
            ca_reg     <= c2_reg;
            cb_reg     <= ca_reg;
            vld1_reg   <= 1'b1;
            vld2_reg   <= vld1_reg;
        end
    end

    assign load = ~out_valid_reg | out_ready;

    generate
        for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
            logic [NTAPS-1:0]    s1_reg, s2_reg;
            logic [NPAD-1:0]     s2_zero_pad, s2_one_pad;
            logic                prev_reg, ev_a_reg, ev_b_reg, sat_b_reg;
            logic [2:0]          grp_sum_reg [NGRP];
            logic [NGRP-1:0]     grp_all_reg;
            logic [FINE_W-1:0]   fine_b_reg, fine_next;
            logic                pend_full_reg, pend_sat_reg, ovf_reg;
            logic [FINE_W-1:0]   pend_fine_reg;
            logic [COARSE_W-1:0] pend_coarse_reg;
            logic                hit, pop, drop;

            // Padding taps count as 0 for the sum and as 1 for saturation.
            always_comb begin
                s2_zero_pad              = '0;
                s2_zero_pad[NTAPS-1:0]   = s2_reg;
                s2_one_pad               = '1;
                s2_one_pad[NTAPS-1:0]    = s2_reg;
            end

            always_comb begin
                fine_next = '0;
                for (int g = 0; g < NGRP; g++) begin
                    fine_next = fine_next + FINE_W'(grp_sum_reg[g]);
                end
            end

            // prev_reg holds 1 until the first real sample reaches s2, so a line
            // already high at reset release is not mistaken for an edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_reg      <= '0;
                    s2_reg      <= '0;
                    prev_reg    <= 1'b1;
                    ev_a_reg    <= 1'b0;
                    ev_b_reg    <= 1'b0;
                    grp_all_reg <= '0;
                    fine_b_reg  <= '0;
                    sat_b_reg   <= 1'b0;
                    for (int g = 0; g < NGRP; g++) begin
                        grp_sum_reg[g] <= '0;
                    end
                end else begin
                    s1_reg   <= taps[gi*NTAPS +: NTAPS];
                    s2_reg   <= s1_reg;
                    if (vld2_reg) begin
                        prev_reg <= s2_reg[0];
                    end
                    ev_a_reg <= en & vld2_reg & s2_reg[0] & ~prev_reg;
                    for (int g = 0; g < NGRP; g++) begin
                        grp_sum_reg[g] <= {2'b00, s2_zero_pad[4*g]}   + {2'b00, s2_zero_pad[4*g+1]}
                                        + {2'b00, s2_zero_pad[4*g+2]} + {2'b00, s2_zero_pad[4*g+3]};
                        grp_all_reg[g] <= &s2_one_pad[4*g +: 4];
                    end
                    ev_b_reg   <= ev_a_reg;
                    fine_b_reg <= fine_next;
                    sat_b_reg  <= &grp_all_reg;
                end
            end

            assign hit  = load & gnt_vld & (gnt_idx == CH_W'(gi));
            assign pop  = hit & pend_full_reg;
            assign drop = ev_b_reg & pend_full_reg & ~pop;

            always_ff @(posedge clk) begin
                if (rst) begin
                    pend_full_reg   <= 1'b0;
                    pend_fine_reg   <= '0;
                    pend_coarse_reg <= '0;
                    pend_sat_reg    <= 1'b0;
                    ovf_reg         <= 1'b0;
                end else begin
                    if (pend_full_reg) begin
                        if (ev_b_reg && pop) begin
                            pend_fine_reg   <= fine_b_reg;
                            pend_coarse_reg <= cb_reg;
                            pend_sat_reg    <= sat_b_reg;
                        end else if (pop) begin
                            pend_full_reg <= 1'b0;
                        end
                    end else if (ev_b_reg && !hit) begin
                        pend_full_reg   <= 1'b1;
                        pend_fine_reg   <= fine_b_reg;
                        pend_coarse_reg <= cb_reg;
                        pend_sat_reg    <= sat_b_reg;
                    end
                    if (drop) begin
                        ovf_reg <= 1'b1;
                    end else if (ovf_clr) begin
                        ovf_reg <= 1'b0;
                    end
                end
            end

            assign cand_vld[gi]    = pend_full_reg | ev_b_reg;
            assign cand_fine[gi]   = pend_full_reg ? pend_fine_reg   : fine_b_reg;
            assign cand_coarse[gi] = pend_full_reg ? pend_coarse_reg : cb_reg;
            assign cand_sat[gi]    = pend_full_reg ? pend_sat_reg    : sat_b_reg;
            assign ovf[gi]         = ovf_reg;
        end
    endgenerate

    // Round-robin search starting at the pointer.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 0; k < NCHAN; k++) begin
            idx = CH_W'((int'(ptr_reg) + k) % NCHAN);
            if (!gnt_vld && cand_vld[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
        ptr_next = CH_W'((int'(gnt_idx) + 1) % NCHAN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_chan_reg   <= '0;
            out_fine_reg   <= '0;
            out_coarse_reg <= '0;
            out_sat_reg    <= 1'b0;
            ptr_reg        <= '0;
        end else if (load) begin
            out_valid_reg <= gnt_vld;
            if (gnt_vld) begin
                out_chan_reg   <= gnt_idx;
                out_fine_reg   <= cand_fine[gnt_idx];
                out_coarse_reg <= cand_coarse[gnt_idx];
                out_sat_reg    <= cand_sat[gnt_idx];
                ptr_reg        <= ptr_next;
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_chan   = out_chan_reg;
    assign out_fine   = out_fine_reg;
    assign out_coarse = out_coarse_reg;
    assign out_sat    = out_sat_reg;

endmodule
